secded_stream_decoder: RTL and testbench

//  Parametrised, pipelined extended-Hamming (SECDED) decoder for a valid/ready stream.

---
 rtl/secded_pkg.sv | 23 ++
 rtl/secded_syndrome.sv | 22 ++
 rtl/secded_stream_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_secded_stream_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared definitions for the SECDED (extended Hamming) decoder and its encoder.
package secded_pkg;

  typedef enum logic [1:0] {
    FLAG_NONE   = 2'b00,
    FLAG_CORR   = 2'b01,
    FLAG_DOUBLE = 2'b10,
    FLAG_RANGE  = 2'b11
  } flag_e;

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int unsigned secded_parity_bits(input int unsigned data_w);
    int unsigned p;
    p = 1;
    while ((32'd1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  function automatic logic is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall-parity check of one codeword.
module secded_syndrome
  import secded_pkg::*;
#(
  parameter int unsigned CODE_W = 8,
  parameter int unsigned P      = 3
) (
  input  logic [CODE_W-1:0] code,
  output logic [P-1:0]      syndrome,
  output logic              ovf
);

  // Syndrome is the XOR of the positions of all set Hamming bits.
  always_comb begin
    syndrome = '0;
    for (int unsigned i = 0; i < CODE_W - 1; i++) begin
      if (code[i]) syndrome = syndrome ^ P'(i + 1);
    end
    ovf = ^code;
  end

endmodule

// File: rtl/secded_stream_decoder.sv
// Two-stage pipelined SECDED decoder on a valid/ready stream with saturating
// error counters. Optional SECDED_ERR_LOG_EN adds a sticky log of the first
// uncorrectable result delivered.
module secded_stream_decoder
  import secded_pkg::*;
#(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned P      = secded_parity_bits(DATA_W),
  localparam int unsigned CODE_W = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [DATA_W-1:0] out_data,
  output logic [P-1:0]      out_syndrome,
  output logic [1:0]        out_flag,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
`ifdef SECDED_ERR_LOG_EN
  ,
  output logic              log_valid,
  output logic [P-1:0]      log_syndrome,
  output logic [CODE_W-1:0] log_code
`endif
);

  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic [P-1:0]      s1_syn_q, s1_syn_d;
  logic              s1_ovf_q, s1_ovf_d;
  logic              out_valid_q, out_valid_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [P-1:0]      out_syn_q, out_syn_d;
  flag_e             out_flag_q, out_flag_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;
`ifdef SECDED_ERR_LOG_EN
  logic              log_valid_q, log_valid_d;
  logic [P-1:0]      log_syn_q, log_syn_d;
  logic [CODE_W-1:0] log_code_q, log_code_d;
`endif

  logic [P-1:0]      in_syn;
  logic              in_ovf;
  logic              s1_ready, s2_ready, deliver, uncorr;
  flag_e             s2_flag;
  logic [CODE_W-1:0] s2_code;
  logic [DATA_W-1:0] s2_data;
  int unsigned       k;

  secded_syndrome #(.CODE_W(CODE_W), .P(P)) u_syndrome (
    .code     (in_code),
    .syndrome (in_syn),
    .ovf      (in_ovf)
  );

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign deliver  = out_valid_q && out_ready;
  assign uncorr   = (out_flag_q == FLAG_DOUBLE) || (out_flag_q == FLAG_RANGE);

  // Classify the stage-1 word, apply the correction, extract data bits.
  always_comb begin
    s2_code = s1_code_q;
    s2_flag = FLAG_NONE;
    s2_data = '0;
    k       = 0;
    if (s1_syn_q == '0) begin
      if (s1_ovf_q) begin
        s2_flag            = FLAG_CORR;
        s2_code[CODE_W-1]  = ~s1_code_q[CODE_W-1];
      end
    end else if (!s1_ovf_q) begin
      s2_flag = FLAG_DOUBLE;
    end else if (32'(s1_syn_q) > CODE_W - 1) begin
      s2_flag = FLAG_RANGE;
    end else begin
      s2_flag = FLAG_CORR;
      for (int unsigned i = 0; i < CODE_W - 1; i++) begin
        if (32'(s1_syn_q) == i + 1) s2_code[i] = ~s1_code_q[i];
      end
    end
    for (int unsigned i = 0; i < CODE_W - 1; i++) begin
      if (!is_pow2(i + 1)) begin
        s2_data[k] = s2_code[i];
        k++;
      end
    end
  end

  // Pipeline advance, counter and log next-state.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_code_d    = s1_code_q;
    s1_syn_d     = s1_syn_q;
    s1_ovf_d     = s1_ovf_q;
    out_valid_d  = out_valid_q;
    out_code_d   = out_code_q;
    out_data_d   = out_data_q;
    out_syn_d    = out_syn_q;
    out_flag_d   = out_flag_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = in_code;
        s1_syn_d  = in_syn;
        s1_ovf_d  = in_ovf;
      end
    end
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_code_d = s2_code;
        out_data_d = s2_data;
        out_syn_d  = s1_syn_q;
        out_flag_d = s2_flag;
      end
    end
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (deliver) begin
      if (out_flag_q == FLAG_CORR && corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (uncorr && uncorr_cnt_q != '1) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
`ifdef SECDED_ERR_LOG_EN
    log_valid_d = log_valid_q;
    log_syn_d   = log_syn_q;
    log_code_d  = log_code_q;
    if (cnt_clr) begin
      log_valid_d = 1'b0;
      log_syn_d   = '0;
      log_code_d  = '0;
    end else if (deliver && uncorr && !log_valid_q) begin
      log_valid_d = 1'b1;
      log_syn_d   = out_syn_q;
      log_code_d  = out_code_q;
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s1_ovf_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_code_q   <= '0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_flag_q   <= FLAG_NONE;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
`ifdef SECDED_ERR_LOG_EN
      log_valid_q  <= 1'b0;
      log_syn_q    <= '0;
      log_code_q   <= '0;
`endif
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_syn_q     <= s1_syn_d;
      s1_ovf_q     <= s1_ovf_d;
      out_valid_q  <= out_valid_d;
      out_code_q   <= out_code_d;
      out_data_q   <= out_data_d;
      out_syn_q    <= out_syn_d;
      out_flag_q   <= out_flag_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
`ifdef SECDED_ERR_LOG_EN
      log_valid_q  <= log_valid_d;
      log_syn_q    <= log_syn_d;
      log_code_q   <= log_code_d;
`endif
    end
  end

  assign in_ready     = s1_ready;
  assign out_valid    = out_valid_q;
  assign out_code     = out_code_q;
  assign out_data     = out_data_q;
  assign out_syndrome = out_syn_q;
  assign out_flag     = out_flag_q;
  assign corr_cnt     = corr_cnt_q;
  assign uncorr_cnt   = uncorr_cnt_q;
`ifdef SECDED_ERR_LOG_EN
  assign log_valid    = log_valid_q;
  assign log_syndrome = log_syn_q;
  assign log_code     = log_code_q;
`endif

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Directed bench for secded_stream_decoder: three instances cover the default
// configuration, a 2-bit counter width and a 5-bit data width.
module tb_secded_stream_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: DATA_W=4, CNT_W=16
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clr;
  logic [7:0]  a_in_code, a_out_code;
  logic [3:0]  a_out_data;
  logic [2:0]  a_out_syn;
  logic [1:0]  a_out_flag;
  logic [15:0] a_corr, a_uncorr;
  // Instance B: DATA_W=4, CNT_W=2
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clr;
  logic [7:0]  b_in_code, b_out_code;
  logic [3:0]  b_out_data;
  logic [2:0]  b_out_syn;
  logic [1:0]  b_out_flag;
  logic [1:0]  b_corr, b_uncorr;
  // Instance C: DATA_W=5, CNT_W=16
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_cnt_clr;
  logic [9:0]  c_in_code, c_out_code;
  logic [4:0]  c_out_data;
  logic [3:0]  c_out_syn;
  logic [1:0]  c_out_flag;
  logic [15:0] c_corr, c_uncorr;
`ifdef SECDED_ERR_LOG_EN
  logic a_log_valid, b_log_valid, c_log_valid;
  logic [2:0] a_log_syn, b_log_syn;
  logic [3:0] c_log_syn;
  logic [7:0] a_log_code, b_log_code;
  logic [9:0] c_log_code;
`endif

  secded_stream_decoder #(.DATA_W(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_in_code),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_code(a_out_code), .out_data(a_out_data),
    .out_syndrome(a_out_syn), .out_flag(a_out_flag), .cnt_clr(a_cnt_clr),
    .corr_cnt(a_corr), .uncorr_cnt(a_uncorr)
`ifdef SECDED_ERR_LOG_EN
    , .log_valid(a_log_valid), .log_syndrome(a_log_syn), .log_code(a_log_code)
`endif
  );

  secded_stream_decoder #(.DATA_W(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_code(b_out_code), .out_data(b_out_data),
    .out_syndrome(b_out_syn), .out_flag(b_out_flag), .cnt_clr(b_cnt_clr),
    .corr_cnt(b_corr), .uncorr_cnt(b_uncorr)
`ifdef SECDED_ERR_LOG_EN
    , .log_valid(b_log_valid), .log_syndrome(b_log_syn), .log_code(b_log_code)
`endif
  );

  secded_stream_decoder #(.DATA_W(5), .CNT_W(16)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_code(c_in_code),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_code(c_out_code), .out_data(c_out_data),
    .out_syndrome(c_out_syn), .out_flag(c_out_flag), .cnt_clr(c_cnt_clr),
    .corr_cnt(c_corr), .uncorr_cnt(c_uncorr)
`ifdef SECDED_ERR_LOG_EN
    , .log_valid(c_log_valid), .log_syndrome(c_log_syn), .log_code(c_log_code)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated word through instance A: outputs two cycles later, counters one after.
  task automatic run_word(input logic [7:0] code, input logic [7:0] e_code, input logic [3:0] e_data,
                          input logic [2:0] e_syn, input logic [1:0] e_flag,
                          input logic [15:0] e_corr, input logic [15:0] e_uncorr);
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_code  = code;
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    check_eq("word_valid", 32'(a_out_valid), 32'd1);
    check_eq("word_code",  32'(a_out_code),  32'(e_code));
    check_eq("word_data",  32'(a_out_data),  32'(e_data));
    check_eq("word_syn",   32'(a_out_syn),   32'(e_syn));
    check_eq("word_flag",  32'(a_out_flag),  32'(e_flag));
    @(negedge clk);
    check_eq("word_drained", 32'(a_out_valid), 32'd0);
    check_eq("word_corr",    32'(a_corr),      32'(e_corr));
    check_eq("word_uncorr",  32'(a_uncorr),    32'(e_uncorr));
  endtask

  // Stream words and their hand-decoded results (data 0,1,2,B,F,B; last has overall bit flipped).
  logic [7:0] stream_in   [6] = '{8'h00, 8'h87, 8'h99, 8'h55, 8'hFF, 8'hD5};
  logic [7:0] stream_code [6] = '{8'h00, 8'h87, 8'h99, 8'h55, 8'hFF, 8'h55};
  logic [3:0] stream_data [6] = '{4'h0, 4'h1, 4'h2, 4'hB, 4'hF, 4'hB};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned tx, rx, stall_seen;
    logic [7:0] held;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_code = '0; a_out_ready = 1'b1; a_cnt_clr = 1'b0;
    b_in_valid = 1'b0; b_in_code = '0; b_out_ready = 1'b1; b_cnt_clr = 1'b0;
    c_in_valid = 1'b0; c_in_code = '0; c_out_ready = 1'b1; c_cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_out_code",  32'(a_out_code),  32'd0);
    check_eq("rst_out_data",  32'(a_out_data),  32'd0);
    check_eq("rst_out_flag",  32'(a_out_flag),  32'd0);
    check_eq("rst_corr",      32'(a_corr),      32'd0);
    check_eq("rst_uncorr",    32'(a_uncorr),    32'd0);
    check_eq("rst_in_ready",  32'(a_in_ready),  32'd1);
    rst = 1'b0;

    // Clean, single-bit, overall-bit and double errors.
    run_word(8'h55, 8'h55, 4'hB, 3'd0, 2'b00, 16'd0, 16'd0);
    run_word(8'h45, 8'h55, 4'hB, 3'd5, 2'b01, 16'd1, 16'd0);
`ifdef SECDED_ERR_LOG_EN
    check_eq("log_idle", 32'(a_log_valid), 32'd0);
`endif
    run_word(8'hD5, 8'h55, 4'hB, 3'd0, 2'b01, 16'd2, 16'd0);
    run_word(8'h56, 8'h56, 4'hB, 3'd3, 2'b10, 16'd2, 16'd1);
`ifdef SECDED_ERR_LOG_EN
    check_eq("log_valid", 32'(a_log_valid), 32'd1);
    check_eq("log_syn",   32'(a_log_syn),   32'd3);
    check_eq("log_code",  32'(a_log_code),  32'h56);
`endif

    // Back-to-back stream with out_ready low for loop cycles 3..5.
    tx = 0; rx = 0; stall_seen = 0; held = '0;
    for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
      @(negedge clk);
      a_out_ready = !(cyc >= 3 && cyc <= 5);
      a_in_valid  = (tx < 6);
      a_in_code   = (tx < 6) ? stream_in[tx] : 8'h00;
      #1;
      if (cyc == 3) held = a_out_code;
      if (cyc == 4 || cyc == 5) begin
        check_eq("stall_valid", 32'(a_out_valid), 32'd1);
        check_eq("stall_hold",  32'(a_out_code),  32'(held));
      end
      if (a_in_valid && !a_in_ready) stall_seen++;
      if (a_out_valid && a_out_ready) begin
        check_eq("stream_code", 32'(a_out_code), 32'(stream_code[rx]));
        check_eq("stream_data", 32'(a_out_data), 32'(stream_data[rx]));
        rx++;
      end
      if (a_in_valid && a_in_ready) tx++;
    end
    check_eq("stream_rx",    rx, 32'd6);
    check_eq("stream_tx",    tx, 32'd6);
    check_eq("stream_stall", stall_seen, 32'd3);
    @(negedge clk);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    check_eq("stream_corr",   32'(a_corr),   32'd3);
    check_eq("stream_uncorr", 32'(a_uncorr), 32'd1);

    // Saturation with 2-bit counters, then clear during a delivery.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1;
      b_in_code  = 8'h45;
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("sat_corr",   32'(b_corr),   32'd3);
    check_eq("sat_uncorr", 32'(b_uncorr), 32'd0);
    @(negedge clk);
    b_in_valid = 1'b1;
    b_in_code  = 8'h45;
    @(negedge clk);
    b_in_valid = 1'b0;
    @(negedge clk);
    check_eq("clr_deliver", 32'(b_out_valid), 32'd1);
    b_cnt_clr = 1'b1;
    @(negedge clk);
    b_cnt_clr = 1'b0;
    check_eq("clr_corr",    32'(b_corr),      32'd0);
    check_eq("clr_drained", 32'(b_out_valid), 32'd0);

    // DATA_W=5: positions 1,4,9 flipped from the all-zero codeword.
    @(negedge clk);
    c_in_valid = 1'b1;
    c_in_code  = 10'h109;
    @(negedge clk);
    c_in_valid = 1'b0;
    @(negedge clk);
    check_eq("range_valid", 32'(c_out_valid), 32'd1);
    check_eq("range_syn",   32'(c_out_syn),   32'd12);
    check_eq("range_flag",  32'(c_out_flag),  32'd3);
    check_eq("range_code",  32'(c_out_code),  32'h109);
    check_eq("range_data",  32'(c_out_data),  32'h10);
    @(negedge clk);
    check_eq("range_uncorr", 32'(c_uncorr), 32'd1);

    // Reset while words are in flight.
    @(negedge clk);
    c_in_valid = 1'b1;
    c_in_code  = 10'h000;
    repeat (2) @(negedge clk);
    check_eq("midrst_before", 32'(c_out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_valid",  32'(c_out_valid), 32'd0);
    check_eq("midrst_uncorr", 32'(c_uncorr),    32'd0);
    rst = 1'b0;
    c_in_valid = 1'b0;
    @(negedge clk);
    check_eq("midrst_dropped", 32'(c_out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
